alu_arbiter: RTL and testbench

- Shares the single registered ALU of the multicycle processor between two requesters with a req/ack handshake.
- Typical requesters: requester 0 is the main datapath sequencer; requester 1 is the PC/branch-target unit.
- Latches the winner's operands and drives the ALU inputs from registers. It waits out the ALU's fixed latency, captures the result and returns it with a one-cycle ack.
- Computes the zero flag locally from the captured result. The ALU's own zero output is not consumed.

---
 rtl/alu_arbiter_if.sv | 34 +++
 rtl/alu_arbiter.sv | 157 +++++++++++++++
 tb/tb_alu_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Requester and ALU-side signals of alu_arbiter, bundled for the port list.
// slave = arbiter side, master = requesters plus the shared ALU.
interface alu_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [1:0]       ctrl0;
  logic [1:0]       ctrl1;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             owner;
  logic [WIDTH-1:0] alu_scrA;
  logic [WIDTH-1:0] alu_scrB;
  logic [1:0]       aluctrl;
  logic [WIDTH-1:0] alu_result;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, ctrl0, ctrl1, alu_result,
    output ack0, ack1, result, zero, busy, owner, alu_scrA, alu_scrB, aluctrl
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, ctrl0, ctrl1, alu_result,
    input  ack0, ack1, result, zero, busy, owner, alu_scrA, alu_scrB, aluctrl
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for the shared registered ALU: latch winner, wait ALU_LAT, capture, ack.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins ties); default is round-robin.
module alu_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, DONE} state_e;

  localparam logic [2:0] CNT_LOAD = 3'(ALU_LAT - 1);

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] scr_a_q, scr_a_d;
  logic [WIDTH-1:0] scr_b_q, scr_b_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             owner_q, owner_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             cand0, cand1;
  logic             grant, win;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic             last_grant_q, last_grant_d;
`endif

  // Arbitration only happens in IDLE and DONE; in DONE the finishing owner is masked.
  always_comb begin
    cand0 = bus.req0 & ((state_q == IDLE) | ((state_q == DONE) &  owner_q));
    cand1 = bus.req1 & ((state_q == IDLE) | ((state_q == DONE) & ~owner_q));
    if (cand0 && cand1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      win = 1'b0;
`else
      win = ~last_grant_q;
`endif
    end else begin
      win = cand1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    scr_a_d  = scr_a_q;
    scr_b_d  = scr_b_q;
    ctrl_d   = ctrl_q;
    result_d = result_q;
    zero_d   = zero_q;
    owner_d  = owner_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    grant    = 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (cand0 || cand1) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == 3'd0) begin
          state_d = CAPT;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      CAPT: begin
        result_d = bus.alu_result;
        zero_d   = (bus.alu_result == '0);
        if (owner_q) begin
          ack1_d = 1'b1;
        end else begin
          ack0_d = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        if (cand0 || cand1) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      owner_d = win;
      cnt_d   = CNT_LOAD;
      scr_a_d = win ? bus.a1    : bus.a0;
      scr_b_d = win ? bus.b1    : bus.b0;
      ctrl_d  = win ? bus.ctrl1 : bus.ctrl0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_d = win;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      scr_a_q  <= '0;
      scr_b_q  <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      owner_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      scr_a_q  <= scr_a_d;
      scr_b_q  <= scr_b_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      owner_q  <= owner_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.owner    = owner_q;
  assign bus.alu_scrA = scr_a_q;
  assign bus.alu_scrB = scr_b_q;
  assign bus.aluctrl  = ctrl_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level reference model plus directed cases.
module tb_alu_arbiter;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned LAT   = 1;
  localparam int unsigned LAT3  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();
  alu_arbiter_if #(.WIDTH(WIDTH)) bus3 ();

  alu_arbiter #(.WIDTH(WIDTH), .ALU_LAT(LAT))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  alu_arbiter #(.WIDTH(WIDTH), .ALU_LAT(LAT3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Requester-side stimulus for the main DUT
  logic [1:0]       rq;
  logic [WIDTH-1:0] ra [2];
  logic [WIDTH-1:0] rb [2];
  logic [1:0]       rc [2];
  int unsigned      pol;
  logic             perturb;

  assign bus.req0  = rq[0];
  assign bus.req1  = rq[1];
  assign bus.a0    = ra[0];
  assign bus.b0    = rb[0];
  assign bus.ctrl0 = rc[0];
  assign bus.a1    = ra[1];
  assign bus.b1    = rb[1];
  assign bus.ctrl1 = rc[1];

  logic             req3;
  logic [WIDTH-1:0] a3, b3;
  logic [1:0]       c3;
  assign bus3.req0  = 1'b0;
  assign bus3.a0    = '0;
  assign bus3.b0    = '0;
  assign bus3.ctrl0 = '0;
  assign bus3.req1  = req3;
  assign bus3.a1    = a3;
  assign bus3.b1    = b3;
  assign bus3.ctrl1 = c3;

  // Shared ALU models: result appears ALU_LAT edges after the inputs
  logic [WIDTH-1:0] pipe  [LAT];
  logic [WIDTH-1:0] pipe3 [LAT3];
  always @(posedge clk) begin
    pipe[0] <= alu_fn(bus.alu_scrA, bus.alu_scrB, bus.aluctrl);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    pipe3[0] <= alu_fn(bus3.alu_scrA, bus3.alu_scrB, bus3.aluctrl);
    for (int i = 1; i < LAT3; i++) pipe3[i] <= pipe3[i-1];
  end
  assign bus.alu_result  = pipe[LAT-1];
  assign bus3.alu_result = pipe3[LAT3-1];

  // Reference model: grant time, capture time = grant + LAT + 1, release one edge later
  int unsigned      edge_n = 0;
  logic             m_busy, m_owner, m_last, m_zero;
  logic [WIDTH-1:0] m_a, m_b, m_res;
  logic [1:0]       m_op, m_ack;
  int unsigned      m_cap, m_grant_edge;

  int               ack_idx  [$];
  logic [WIDTH-1:0] ack_res  [$];
  logic             ack_zero [$];
  int unsigned      ack_edge [$];

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_zero = 1'b0;
    m_a = '0; m_b = '0; m_res = '0; m_op = '0; m_ack = '0;
    m_cap = 0; m_grant_edge = 0;
  endtask

  function automatic logic pick(input logic [1:0] r);
    if (r == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 1'b0;
`else
      return ~m_last;
`endif
    end
    return r[1];
  endfunction

  task automatic model_grant(input logic w);
    m_owner = w; m_last = w;
    m_a = ra[w]; m_b = rb[w]; m_op = rc[w];
    m_grant_edge = edge_n;
    m_cap = edge_n + LAT + 1;
    m_busy = 1'b1;
  endtask

  task automatic model_edge();
    edge_n++;
    m_ack = '0;
    if (!m_busy) begin
      if (rq != 2'b00) model_grant(pick(rq));
    end else if (edge_n == m_cap) begin
      m_res = alu_fn(m_a, m_b, m_op);
      m_zero = (m_res == '0);
      m_ack[m_owner] = 1'b1;
    end else if (edge_n == m_cap + 1) begin
      if (rq[~m_owner]) model_grant(~m_owner);
      else m_busy = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check_eq("busy",   WIDTH'(bus.busy),    WIDTH'(m_busy));
    check_eq("owner",  WIDTH'(bus.owner),   WIDTH'(m_owner));
    check_eq("ack0",   WIDTH'(bus.ack0),    WIDTH'(m_ack[0]));
    check_eq("ack1",   WIDTH'(bus.ack1),    WIDTH'(m_ack[1]));
    check_eq("result", bus.result,          m_res);
    check_eq("zero",   WIDTH'(bus.zero),    WIDTH'(m_zero));
    check_eq("scrA",   bus.alu_scrA,        m_a);
    check_eq("scrB",   bus.alu_scrB,        m_b);
    check_eq("aluctrl", WIDTH'(bus.aluctrl), WIDTH'(m_op));
  endtask

  task automatic new_ops(input int i);
    case ($urandom_range(3))
      0:       ra[i] = '1;
      1:       ra[i] = '0;
      default: ra[i] = $urandom;
    endcase
    rb[i] = ($urandom_range(3) == 0) ? ra[i] : $urandom;
    rc[i] = 2'($urandom_range(3));
    rq[i] = 1'b1;
  endtask

  task automatic react();
    for (int i = 0; i < 2; i++) begin
      logic a;
      a = (i == 0) ? bus.ack0 : bus.ack1;
      if (a) begin
        ack_idx.push_back(i);
        ack_res.push_back(bus.result);
        ack_zero.push_back(bus.zero);
        ack_edge.push_back(edge_n);
        if (pol == 1) new_ops(i);
        else rq[i] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    if (perturb && m_busy && !m_owner && edge_n == m_grant_edge) ra[0] = 32'd100;
    if (pol == 2) begin
      for (int i = 0; i < 2; i++)
        if (!rq[i] && $urandom_range(2) == 0) new_ops(i);
    end
    @(negedge clk);
    check_outputs();
    react();
  endtask

  task automatic run_until_idle(input string tag, input int unsigned bound);
    int unsigned k;
    k = 0;
    do begin
      cycle();
      k++;
    end while ((m_busy || rq != 2'b00) && k < bound);
    check_eq(tag, WIDTH'(bus.busy), '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rq = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned base, busy_n, ack_at, acks0, nacks;
    logic [WIDTH-1:0] got_res;
    logic got_zero;

    rst_n = 1'b0;
    rq = '0; pol = 0; perturb = 1'b0;
    for (int i = 0; i < 2; i++) begin ra[i] = '0; rb[i] = '0; rc[i] = '0; end
    req3 = 1'b0; a3 = '0; b3 = '0; c3 = '0;
    do_reset();

    // ALU_LAT = 3 instance: FFFFFFFF + 1 on requester 1
    @(negedge clk);
    req3 = 1'b1; a3 = '1; b3 = 32'd1; c3 = 2'd0;
    busy_n = 0; ack_at = 0; acks0 = 0; got_res = 'x; got_zero = 1'bx;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus3.busy) busy_n++;
      if (bus3.ack0) acks0++;
      if (bus3.ack1 && ack_at == 0) begin
        ack_at = k; got_res = bus3.result; got_zero = bus3.zero; req3 = 1'b0;
      end
    end
    check_eq("l3_busy_cycles", WIDTH'(busy_n), WIDTH'(5));
    check_eq("l3_ack_cycle",   WIDTH'(ack_at), WIDTH'(5));
    check_eq("l3_result",      got_res,        '0);
    check_eq("l3_zero",        WIDTH'(got_zero), WIDTH'(1));
    check_eq("l3_ack0_none",   WIDTH'(acks0),  '0);

    // Single req0: 5 - 3
    base = ack_idx.size();
    ra[0] = 32'd5; rb[0] = 32'd3; rc[0] = 2'd1; rq[0] = 1'b1;
    run_until_idle("t1_idle", 20);
    check_eq("t1_nacks",  WIDTH'(ack_idx.size() - base), WIDTH'(1));
    check_eq("t1_idx",    WIDTH'(ack_idx[base]),  '0);
    check_eq("t1_result", ack_res[base],          WIDTH'(2));
    check_eq("t1_zero",   WIDTH'(ack_zero[base]), '0);
    check_eq("t1_latency", WIDTH'(ack_edge[base] - m_grant_edge), WIDTH'(LAT + 1));

    // Simultaneous requests from reset
    do_reset();
    base = ack_idx.size();
    ra[0] = 32'd7; rb[0] = 32'd7; rc[0] = 2'd1;
    ra[1] = 32'd7; rb[1] = 32'd7; rc[1] = 2'd0;
    rq = 2'b11;
    run_until_idle("t2_idle", 30);
    check_eq("t2_nacks", WIDTH'(ack_idx.size() - base), WIDTH'(2));
    check_eq("t2_first_idx",   WIDTH'(ack_idx[base]),    '0);
    check_eq("t2_first_res",   ack_res[base],            '0);
    check_eq("t2_first_zero",  WIDTH'(ack_zero[base]),   WIDTH'(1));
    check_eq("t2_second_idx",  WIDTH'(ack_idx[base+1]),  WIDTH'(1));
    check_eq("t2_second_res",  ack_res[base+1],          WIDTH'(14));
    check_eq("t2_second_zero", WIDTH'(ack_zero[base+1]), '0);
    check_eq("t2_gap", WIDTH'(ack_edge[base+1] - ack_edge[base]), WIDTH'(LAT + 2));

    // Continuous re-requesting from both: grants alternate 0,1,0,1,...
    base = ack_idx.size();
    pol = 1;
    new_ops(0); new_ops(1);
    for (int k = 0; k < 80 && ack_idx.size() < base + 6; k++) cycle();
    pol = 0;
    nacks = ack_idx.size() - base;
    check_eq("t3_count", WIDTH'(nacks >= 6), WIDTH'(1));
    for (int k = 0; k < 6 && k < int'(nacks); k++)
      check_eq("t3_alternate", WIDTH'(ack_idx[base+k]), WIDTH'(k % 2));
    for (int k = 1; k < 6 && k < int'(nacks); k++)
      check_eq("t3_spacing", WIDTH'(ack_edge[base+k] - ack_edge[base+k-1]), WIDTH'(LAT + 2));
    run_until_idle("t3_idle", 30);

    // Operand change on a0 while the op is in flight
    base = ack_idx.size();
    perturb = 1'b1;
    ra[0] = 32'd10; rb[0] = 32'd4; rc[0] = 2'd1; rq[0] = 1'b1;
    run_until_idle("t4_idle", 20);
    perturb = 1'b0;
    check_eq("t4_result", ack_res[base], WIDTH'(6));

    // Reset asserted during ISSUE
    base = ack_idx.size();
    ra[0] = 32'h1234; rb[0] = 32'h1; rc[0] = 2'd0; rq[0] = 1'b1;
    for (int k = 0; k < 5 && !m_busy; k++) cycle();
    check_eq("t5_in_flight", WIDTH'(bus.busy), WIDTH'(1));
    rst_n = 1'b0;
    rq = '0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) cycle();
    check_eq("t5_no_ack", WIDTH'(ack_idx.size() - base), '0);
    ra[0] = 32'd9; rb[0] = 32'd3; rc[0] = 2'd2; rq[0] = 1'b1;
    run_until_idle("t5_idle", 20);
    check_eq("t5_fresh_nacks", WIDTH'(ack_idx.size() - base), WIDTH'(1));
    check_eq("t5_fresh_res",   ack_res[base], WIDTH'(11));

    // Randomized traffic
    pol = 2;
    for (int k = 0; k < 400; k++) cycle();
    pol = 0;
    run_until_idle("t6_drain", 60);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
